// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// One operation in flight; MUL holds operands for MUL_CYCLES cycles, unsupported opcodes answer with rsp_err.

module alu_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int OPCODE_LENGTH = 4,
  parameter int MUL_CYCLES    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_a,
  input  logic [DATA_WIDTH-1:0]    req0_b,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_a,
  input  logic [DATA_WIDTH-1:0]    req1_b,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_id,
  output logic                     rsp_err,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_cc,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int CNT_W = (MUL_CYCLES < 2) ? 1 : $clog2(MUL_CYCLES + 1);
  localparam logic [OPCODE_LENGTH-1:0] OP_MUL = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state, state_nxt;
  logic                     grant;
  logic                     accept;
  logic                     op_ok;
  logic [OPCODE_LENGTH-1:0] sel_op;
  logic                     last_grant;
  logic [DATA_WIDTH-1:0]    a_q, b_q;
  logic [OPCODE_LENGTH-1:0] op_q;
  logic                     id_q;
  logic [CNT_W-1:0]         cnt;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;
  assign sel_op     = grant ? req1_op : req0_op;
  assign op_ok      = sel_op inside {OP_MUL, OP_OR, OP_ADD, OP_SUB};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    alu_srca  = '0;
    alu_srcb  = '0;
    alu_cc    = '0;
    case (state)
      IDLE: if (accept) state_nxt = op_ok ? EXEC : RESP;
      EXEC: begin
        alu_srca = a_q;
        alu_srcb = b_q;
        alu_cc   = op_q;
        if (cnt == CNT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      cnt        <= '0;
      rsp_data   <= '0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q        <= grant ? req1_a : req0_a;
          b_q        <= grant ? req1_b : req0_b;
          op_q       <= sel_op;
          id_q       <= grant;
          last_grant <= grant;
          if (op_ok) begin
            cnt <= (sel_op == OP_MUL) ? CNT_W'(MUL_CYCLES) : CNT_W'(1);
          end else begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            rsp_id   <= grant;
          end
        end
        EXEC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rsp_data <= alu_result;
            rsp_err  <= 1'b0;
            rsp_id   <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed-vector bench for alu_arbiter with a behavioural ALU attached

module tb_alu_arbiter;

  localparam int DW = 64;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OW-1:0] req0_op, req1_op;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [DW-1:0] alu_srca, alu_srcb, alu_result;
  logic [OW-1:0] alu_cc;

  int vectors = 0;
  int miscompares = 0;

  alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .MUL_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_cc(alu_cc), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // External combinational ALU the arbiter is sharing
  always_comb begin
    case (alu_cc)
      4'b0000: alu_result = alu_srca * alu_srcb;
      4'b0001: alu_result = alu_srca | alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0110: alu_result = alu_srca - alu_srcb;
      default: alu_result = '0;
    endcase
  end

  task automatic drive_req0(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive_req1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [OW-1:0] op);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready} !== 5'b0 || rsp_data !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp got v=%b id=%b err=%b data=%0h rdy=%b%b exp all 0",
               rsp_valid, rsp_id, rsp_err, rsp_data, req0_ready, req1_ready);
    end
    vectors++;
    if (alu_srca !== '0 || alu_srcb !== '0 || alu_cc !== '0) begin
      miscompares++;
      $display("FAIL reset_alu got a=%0h b=%0h cc=%b exp 0", alu_srca, alu_srcb, alu_cc);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    @(negedge clk);
    drive_req0(5, 7, 4'b0010);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL add_ready got %b exp 10", {req0_ready, req1_ready});
    end
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || alu_srca !== 64'd5 || alu_srcb !== 64'd7 || alu_cc !== 4'b0010) begin
      miscompares++;
      $display("FAIL add_exec got v=%b a=%0h b=%0h cc=%b exp v=0 a=5 b=7 cc=0010", rsp_valid, alu_srca, alu_srcb, alu_cc);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b100 || rsp_data !== 64'd12 || alu_cc !== 4'b0000 || alu_srca !== '0) begin
      miscompares++;
      $display("FAIL add_rsp got v=%b id=%b err=%b data=%0h cc=%b exp v=1 id=0 err=0 data=c cc=0",
               rsp_valid, rsp_id, rsp_err, rsp_data, alu_cc);
    end
    take_rsp();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++; $display("FAIL add_rsp_drop got %b exp 0", rsp_valid);
    end
  endtask

  task automatic test_tie();
    logic exp_id;
    do_reset();
    drive_req0(10, 3, 4'b0110);
    drive_req1(64'hF0, 64'h0F, 4'b0001);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL tie_first_ready got %b exp 10", {req0_ready, req1_ready});
    end
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    #1;
    vectors++;
    if (req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL tie_exec_ready got %b exp 0", req1_ready);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b100 || rsp_data !== 64'd7 || req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_rsp0 got v=%b id=%b err=%b data=%0h r1=%b exp v=1 id=0 err=0 data=7 r1=0",
               rsp_valid, rsp_id, rsp_err, rsp_data, req1_ready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++; $display("FAIL tie_second_ready got %b exp 1", req1_ready);
    end
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b110 || rsp_data !== 64'hFF) begin
      miscompares++;
      $display("FAIL tie_rsp1 got v=%b id=%b err=%b data=%0h exp v=1 id=1 err=0 data=ff", rsp_valid, rsp_id, rsp_err, rsp_data);
    end
    take_rsp();
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      @(negedge clk);
      drive_req0(i, 1, 4'b0010);
      drive_req1(i, 2, 4'b0010);
      #1;
      vectors++;
      if ({req0_ready, req1_ready} !== {~exp_id, exp_id}) begin
        miscompares++; $display("FAIL tie_rr%0d got %b exp %b", i, {req0_ready, req1_ready}, {~exp_id, exp_id});
      end
      @(posedge clk); @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (rsp_id !== exp_id || rsp_data !== 64'(i + (exp_id ? 2 : 1))) begin
        miscompares++;
        $display("FAIL tie_rr%0d_rsp got id=%b data=%0h exp id=%b data=%0h", i, rsp_id, rsp_data, exp_id, i + (exp_id ? 2 : 1));
      end
      take_rsp();
    end
  endtask

  task automatic test_mul();
    @(negedge clk);
    drive_req1(6, 7, 4'b0000);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++; $display("FAIL mul_ready got %b exp 01", {req0_ready, req1_ready});
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      vectors++;
      if (alu_srca !== 64'd6 || alu_srcb !== 64'd7 || alu_cc !== 4'b0000 || rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mul_hold%0d got a=%0h b=%0h cc=%b v=%b exp a=6 b=7 cc=0000 v=0", i, alu_srca, alu_srcb, alu_cc, rsp_valid);
      end
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b110 || rsp_data !== 64'd42 || alu_srca !== '0) begin
      miscompares++;
      $display("FAIL mul_rsp got v=%b id=%b err=%b data=%0h srca=%0h exp v=1 id=1 err=0 data=2a srca=0",
               rsp_valid, rsp_id, rsp_err, rsp_data, alu_srca);
    end
    take_rsp();
  endtask

  task automatic test_bad_op();
    @(negedge clk);
    drive_req0(3, 4, 4'b1111);
    #1;
    vectors++;
    if (req0_ready !== 1'b1) begin
      miscompares++; $display("FAIL bad_ready got %b exp 1", req0_ready);
    end
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b101 || rsp_data !== '0 ||
        alu_srca !== '0 || alu_srcb !== '0 || alu_cc !== '0) begin
      miscompares++;
      $display("FAIL bad_rsp got v=%b id=%b err=%b data=%0h a=%0h b=%0h cc=%b exp v=1 id=0 err=1 data=0 alu 0",
               rsp_valid, rsp_id, rsp_err, rsp_data, alu_srca, alu_srcb, alu_cc);
    end
    take_rsp();
  endtask

  task automatic test_stall();
    @(negedge clk);
    drive_req0(100, 23, 4'b0010);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    drive_req1(9, 4, 4'b0110);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready} !== 5'b10000 || rsp_data !== 64'd123) begin
        miscompares++;
        $display("FAIL stall%0d got v=%b id=%b err=%b rdy=%b%b data=%0h exp v=1 id=0 err=0 rdy=00 data=7b",
                 i, rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, rsp_data);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      miscompares++; $display("FAIL stall_after got v=%b r1=%b exp v=0 r1=1", rsp_valid, req1_ready);
    end
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id} !== 2'b11 || rsp_data !== 64'd5) begin
      miscompares++; $display("FAIL stall_next got v=%b id=%b data=%0h exp v=1 id=1 data=5", rsp_valid, rsp_id, rsp_data);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    drive_req0(3, 5, 4'b0000);
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || alu_srca !== '0 || alu_srcb !== '0 || alu_cc !== '0 || rsp_data !== '0) begin
      miscompares++;
      $display("FAIL rst_mid got v=%b a=%0h b=%0h cc=%b data=%0h exp all 0", rsp_valid, alu_srca, alu_srcb, alu_cc, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++; $display("FAIL rst_no_rsp%0d got %b exp 0", i, rsp_valid);
      end
    end
    drive_req0(1, 1, 4'b0010);
    drive_req1(2, 2, 4'b0010);
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL rst_tie got %b exp 10", {req0_ready, req1_ready});
    end
    @(posedge clk); @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id} !== 2'b10 || rsp_data !== 64'd2) begin
      miscompares++; $display("FAIL rst_tie_rsp got v=%b id=%b data=%0h exp v=1 id=0 data=2", rsp_valid, rsp_id, rsp_data);
    end
    take_rsp();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive_req1(0, 1, 4'b0110);
    @(posedge clk); @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b110 || rsp_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap got v=%b id=%b err=%b data=%0h exp v=1 id=1 err=0 data=ffffffffffffffff",
               rsp_valid, rsp_id, rsp_err, rsp_data);
    end
    take_rsp();
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_tie();
    test_mul();
    test_bad_op();
    test_stall();
    test_reset_mid_mul();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (ops: MUL 4'b0000, OR 4'b0001, ADD 4'b0010, SUB 4'b0110) between two requesters, e.g. the integer pipe and a multi-cycle/address-generation unit.
- Per requester: valid/ready request handshake. Single valid/ready response channel tagged with requester id.
- Holds operands stable for a configurable number of cycles on MUL and rejects unsupported opcodes.

Parameters:
DATA_WIDTH, 64, operand/result width
OPCODE_LENGTH, 4, ALU control code width
MUL_CYCLES, 3, cycles operands are held for MUL before the result is captured (must be >=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  DATA_WIDTH  requester 0 operand A
req0_b  in  DATA_WIDTH  requester 0 operand B
req0_op  in  OPCODE_LENGTH  requester 0 ALU control code
req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes the response
rsp_data  out  DATA_WIDTH  captured ALU result
rsp_id  out  1  id of the requester that issued the operation
rsp_err  out  1  opcode was unsupported
alu_srca  out  DATA_WIDTH  to ALU SrcA
alu_srcb  out  DATA_WIDTH  to ALU SrcB
alu_cc  out  OPCODE_LENGTH  to ALU ALUCC
alu_result  in  DATA_WIDTH  from ALU ALUResult

Behaviour:
- Reset (async, any state):
  - state=IDLE, last_grant=1.
  - rsp_valid/rsp_data/rsp_id/rsp_err=0; alu_srca/alu_srcb/alu_cc=0.
  - Any in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, EXEC, RESP. Only one operation is in flight at a time.
- IDLE, grant:
  - Only one requester valid: grant that requester.
  - Both valid: grant the requester != last_grant (round-robin).
  - reqX_ready = (state==IDLE) && reqX_valid && grant==X. This is combinational; at most one ready is high. Both readys are 0 in EXEC and RESP.
- Acceptance at edge t0 (valid&&ready):
  - Latch a, b, op and id. Set last_grant=id.
  - op in {0000, 0001, 0010, 0110}: go to EXEC. Load cnt = MUL_CYCLES if op==0000, else 1.
  - Any other op: go to RESP with rsp_err=1, rsp_data=0, rsp_id=id. The ALU is not driven.
- EXEC:
  - alu_srca/alu_srcb/alu_cc = latched values, stable for the whole state.
  - Each edge: cnt decrements. At the edge where cnt==1: rsp_data<=alu_result, rsp_err<=0, rsp_id<=id, go to RESP.
  - Latency: rsp_valid rises at edge t0+1 for OR/ADD/SUB and at edge t0+MUL_CYCLES for MUL.
- RESP:
  - rsp_valid=1. rsp_data/rsp_id/rsp_err held stable until rsp_ready.
  - Edge with rsp_ready=1: go to IDLE, rsp_valid=0. Back-to-back accept is possible in the following IDLE cycle.
  - Minimum issue interval is therefore k+2 cycles (k = 1 or MUL_CYCLES).
  - ALU outputs return to 0 in IDLE and RESP.
- Arithmetic: the result is taken verbatim from alu_result (truncating multiply, wrap-around add/sub). The arbiter performs no arithmetic itself.
- Requester rules:
  - Payload must be stable while valid && !ready.
  - A requester may drop valid before being granted; no state changes.
  - last_grant updates only on acceptance.
- rsp_ready asserted while rsp_valid=0 is ignored.

Test Plan:
- Reset, then req0 ADD a=5 b=7 -> req0_ready at t0; rsp_valid at t0+1 with data=12, id=0, err=0; alu_cc=0010 during EXEC.
- Both valid together, req0 SUB 10-3 and req1 OR 0xF0|0x0F -> req0 served first (data=7, id=0). req1 is granted in the next IDLE (data=0xFF, id=1). Repeat ties alternate 0,1,0,1.
- req1 MUL 6*7 with MUL_CYCLES=3 -> alu_srca=6, alu_srcb=7, alu_cc=0000 held 3 cycles; rsp_valid at t0+3, data=42.
- req0 op=4'b1111 -> rsp_valid at t0 with err=1, data=0; alu_* stay 0.
- rsp_ready held low 5 cycles in RESP -> rsp_* stable, both readys 0 despite req1_valid=1; req1 is accepted the cycle after the rsp handshake.
- Assert rst mid-MUL (cycle 2 of EXEC) -> all outputs 0 immediately; no response after deassert; the next tie grants req0.
- SUB 0-1 -> data=0xFFFF_FFFF_FFFF_FFFF (wrap-around).
